coin_feeder: RTL and testbench

- Front-end coin acceptor that drives the vending FSM's coin interface (coin_in, next) and obeys its check_coin_in flag.
- Buffers classified coins from the coin sensor in a small FIFO and presents them one at a time, each with a clean low-to-high next edge.
- Optionally issues empty "step" pulses while the FSM is busy returning change or dispensing, so the FSM advances without a user button.
- Sits between the coin sensor and soda_top.

---
 rtl/coin_pkg.sv | 10 +
 rtl/coin_feeder_if.sv | 14 +
 rtl/coin_fifo.sv | 39 +++
 rtl/coin_feeder.sv | 86 ++++++++
 tb/tb_coin_feeder.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/coin_pkg.sv
// coin_pkg: coin codes and feeder state encodings shared by the coin feeder slice
package coin_pkg;
  typedef logic [1:0] coin_t;
  localparam coin_t COIN_NONE = 2'b00;
  localparam coin_t COIN_1 = 2'b01;
  localparam coin_t COIN_2 = 2'b10;
  localparam coin_t COIN_5 = 2'b11;
  typedef enum logic [1:0] {IDLE, SETUP, PULSE, GAP} feed_state_t;
  typedef enum logic {MODE_STEP, MODE_COIN} feed_mode_t;
endpackage

// File: rtl/coin_feeder_if.sv
// coin_feeder_if: sensor input, FSM coin handshake and status of the coin feeder
interface coin_feeder_if #(parameter int DEPTH = 4);
  import coin_pkg::*;
  logic sensor_valid;
  coin_t sensor_coin;
  logic check_coin_in;
  coin_t coin_in;
  logic next;
  logic coin_reject;
  logic [$clog2(DEPTH+1)-1:0] fifo_count;
  logic busy;
  modport master(input sensor_valid, sensor_coin, check_coin_in, output coin_in, next, coin_reject, fifo_count, busy);
  modport slave(output sensor_valid, sensor_coin, check_coin_in, input coin_in, next, coin_reject, fifo_count, busy);
endinterface

// File: rtl/coin_fifo.sv
// coin_fifo: DEPTH x 2-bit synchronous FIFO; a push into a full FIFO is taken when the same edge pops
module coin_fifo import coin_pkg::*; #(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH+1),
  localparam int AW = $clog2(DEPTH)
) (
  input logic clk,
  input logic reset,
  input logic push,
  input logic pop,
  input coin_t din,
  output coin_t dout,
  output logic full,
  output logic empty,
  output logic [CW-1:0] count
);
  coin_t mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rd];
  // pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      rd <= rd + AW'(do_pop);
      wr <= wr + AW'(do_push);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  // storage needs no reset; occupancy guards every read
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= din;
endmodule

// File: rtl/coin_feeder.sv
// coin_feeder: buffers sensed coins and presents them to the vending FSM with clean next pulses
module coin_feeder import coin_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES = 2,
  parameter int AUTO_STEP = 1
) (
  input logic clk,
  input logic reset,
  coin_feeder_if.master bus
);
  feed_state_t state, state_n;
  feed_mode_t mode, mode_n;
  logic [7:0] timer, timer_n;
  coin_t coin_q, coin_n, head;
  logic next_q, next_n, busy_q, reject_q, push, pop, full, empty;
  logic [$clog2(DEPTH+1)-1:0] count;
  assign push = bus.sensor_valid && bus.sensor_coin != COIN_NONE;
  coin_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .din(bus.sensor_coin),
    .dout(head), .full(full), .empty(empty), .count(count)
  );
  // transaction sequencer: the head coin stays in the FIFO until its pulse ends
  always_comb begin
    state_n = state;
    mode_n = mode;
    timer_n = timer;
    coin_n = coin_q;
    next_n = next_q;
    pop = 1'b0;
    case (state)
      IDLE:
        if (bus.check_coin_in && !empty) begin
          coin_n = head;
          mode_n = MODE_COIN;
          state_n = SETUP;
        end else if (!bus.check_coin_in && AUTO_STEP != 0) begin
          coin_n = COIN_NONE;
          mode_n = MODE_STEP;
          state_n = SETUP;
        end
      SETUP: begin
        next_n = 1'b1;
        timer_n = 8'(PULSE_CYCLES - 1);
        state_n = PULSE;
      end
      PULSE:
        if (timer == '0) begin
          next_n = 1'b0;
          coin_n = COIN_NONE;
          pop = mode == MODE_COIN;
          timer_n = 8'(GAP_CYCLES - 1);
          state_n = GAP;
        end else timer_n = timer - 8'd1;
      GAP: begin
        state_n = timer == '0 ? IDLE : GAP;
        timer_n = timer == '0 ? timer : timer - 8'd1;
      end
      default: state_n = IDLE;
    endcase
  end
  // registered state and outputs; reset drops next at once
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      mode <= MODE_STEP;
      timer <= '0;
      coin_q <= COIN_NONE;
      next_q <= 1'b0;
      busy_q <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      state <= state_n;
      mode <= mode_n;
      timer <= timer_n;
      coin_q <= coin_n;
      next_q <= next_n;
      busy_q <= state_n != IDLE;
      reject_q <= push && full && !pop;
    end
  assign bus.coin_in = coin_q;
  assign bus.next = next_q;
  assign bus.busy = busy_q;
  assign bus.coin_reject = reject_q;
  assign bus.fifo_count = count;
endmodule

// File: tb/tb_coin_feeder.sv
// tb_coin_feeder: two feeders (steps off/on) driven together and checked against a phase-count model
module tb_coin_feeder;
  localparam int DEPTH = 4;
  localparam int P = 2;
  localparam int G = 2;
  logic clk = 0;
  logic reset = 1;
  logic sv = 0;
  logic [1:0] sc = 0;
  logic chk = 0;
  int n_pass = 0;
  int n_total = 0;
  int mpos[2], mcur[2], miscoin[2], mrej[2], mcnt[2];
  int mq[2][DEPTH];
  int prev_next[2], prev_coin[2];
  coin_feeder_if #(.DEPTH(DEPTH)) b0 ();
  coin_feeder_if #(.DEPTH(DEPTH)) b1 ();
  assign b0.sensor_valid = sv;
  assign b0.sensor_coin = sc;
  assign b0.check_coin_in = chk;
  assign b1.sensor_valid = sv;
  assign b1.sensor_coin = sc;
  assign b1.check_coin_in = chk;
  coin_feeder #(.DEPTH(DEPTH), .PULSE_CYCLES(P), .GAP_CYCLES(G), .AUTO_STEP(0)) u0 (.clk(clk), .reset(reset), .bus(b0));
  coin_feeder #(.DEPTH(DEPTH), .PULSE_CYCLES(P), .GAP_CYCLES(G), .AUTO_STEP(1)) u1 (.clk(clk), .reset(reset), .bus(b1));
  always #5 clk = ~clk;

  task automatic check(string tag, int got, int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mpos[m] = -1;
      mcur[m] = 0;
      miscoin[m] = 0;
      mrej[m] = 0;
      mcnt[m] = 0;
      prev_next[m] = 0;
      prev_coin[m] = 0;
    end
  endtask

  // pos = cycles into the transaction: 0 setup, 1..P pulse, P+1..P+G gap, -1 idle
  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      int pop_now;
      int push_now;
      pop_now = (mpos[m] == P) && miscoin[m] != 0;
      push_now = sv && sc != 0;
      if (mpos[m] < 0) begin
        if (chk && mcnt[m] > 0) begin
          mpos[m] = 0;
          mcur[m] = mq[m][0];
          miscoin[m] = 1;
        end else if (!chk && m == 1) begin
          mpos[m] = 0;
          mcur[m] = 0;
          miscoin[m] = 0;
        end
      end else if (mpos[m] == P + G) mpos[m] = -1;
      else mpos[m]++;
      mrej[m] = push_now && mcnt[m] == DEPTH && !pop_now;
      if (pop_now) begin
        for (int i = 0; i < DEPTH - 1; i++) mq[m][i] = mq[m][i+1];
        mcnt[m]--;
      end
      if (push_now && !mrej[m]) begin
        mq[m][mcnt[m]] = sc;
        mcnt[m]++;
      end
    end
  endtask

  task automatic compare_all();
    for (int m = 0; m < 2; m++) begin
      int gc, gn, gr, gb, gf;
      gc = m ? b1.coin_in : b0.coin_in;
      gn = m ? b1.next : b0.next;
      gr = m ? b1.coin_reject : b0.coin_reject;
      gb = m ? b1.busy : b0.busy;
      gf = m ? b1.fifo_count : b0.fifo_count;
      check($sformatf("u%0d.coin_in", m), gc, (mpos[m] >= 0 && mpos[m] <= P) ? mcur[m] : 0);
      check($sformatf("u%0d.next", m), gn, (mpos[m] >= 1 && mpos[m] <= P) ? 1 : 0);
      check($sformatf("u%0d.coin_reject", m), gr, mrej[m]);
      check($sformatf("u%0d.busy", m), gb, mpos[m] >= 0 ? 1 : 0);
      check($sformatf("u%0d.fifo_count", m), gf, mcnt[m]);
      if (prev_next[m] != 0 && gn != 0) check($sformatf("u%0d.coin_stable", m), gc, prev_coin[m]);
      prev_next[m] = gn;
      prev_coin[m] = gc;
    end
  endtask

  task automatic tick(input logic v, input logic [1:0] c, input logic k);
    sv = v;
    sc = c;
    chk = k;
    @(posedge clk);
    if (reset) model_reset();
    else model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n, input logic k);
    for (int i = 0; i < n; i++) tick(0, 0, k);
  endtask

  initial begin
    model_reset();
    idle(2, 0);
    reset = 0;
    idle(1, 1);
    // single coin
    tick(1, 2'b10, 1);
    idle(8, 1);
    // overflow then drain in order
    tick(1, 2'b01, 0);
    tick(1, 2'b10, 0);
    tick(1, 2'b11, 0);
    tick(1, 2'b01, 0);
    tick(1, 2'b10, 0);
    idle(2, 0);
    idle(30, 1);
    // auto step, then raise the flag mid-transaction
    idle(20, 0);
    idle(3, 1);
    idle(10, 1);
    // full FIFO, push on the popping edge
    for (int i = 0; i < 4; i++) tick(1, 2'(i % 3 + 1), 0);
    idle(1, 0);
    idle(3, 1);
    tick(1, 2'b11, 1);
    idle(30, 1);
    // invalid code while full
    for (int i = 0; i < 4; i++) tick(1, 2'b10, 0);
    tick(1, 2'b00, 0);
    idle(2, 0);
    idle(30, 1);
    // flag falls during the pulse
    tick(1, 2'b01, 1);
    idle(3, 1);
    idle(10, 0);
    idle(4, 1);
    // reset mid-pulse
    tick(1, 2'b11, 1);
    idle(3, 1);
    reset = 1;
    model_reset();
    #1;
    compare_all();
    idle(2, 1);
    reset = 0;
    idle(10, 1);
    // random traffic
    chk = 1;
    for (int i = 0; i < 600; i++) begin
      logic k;
      k = ($urandom_range(0, 7) == 0) ? ~chk : chk;
      tick(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), k);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
